// File: rtl/instr_loader.sv
// Assembles big-endian instruction words from the UART byte stream and drives
// the instruction memory load port until a HALT is committed or memory fills.
module instr_loader #(
    parameter int DATA_WIDTH = 32,
    parameter int MEM_DEPTH  = 32,
    parameter int SIZEOP     = 6
) (
    input  logic                         i_clock,
    input  logic                         i_reset,
    input  logic [7:0]                   i_rx_data,
    input  logic                         i_rx_done,
    input  logic                         i_start,
    output logic [DATA_WIDTH-1:0]        o_instruccion,
    output logic [DATA_WIDTH-1:0]        o_address,
    output logic                         o_loading,
    output logic                         o_wr_en,
    output logic                         o_done,
    output logic                         o_error,
    output logic [$clog2(MEM_DEPTH):0]   o_word_count
);

    // state | meaning
    // IDLE  | waiting for i_start, bytes ignored
    // LOAD  | assembling words and committing them to memory
    // DONE  | HALT committed, bytes ignored until i_start
    // ERR   | memory filled without HALT, bytes ignored until i_start
    typedef enum logic [1:0] {IDLE, LOAD, DONE, ERR} state_t;

    localparam int CW = $clog2(MEM_DEPTH) + 1;
    localparam logic [CW-1:0] MAX_WORDS = CW'(MEM_DEPTH);

    state_t                  state, next_state;
    logic [DATA_WIDTH-9:0]   shift_q;   // first three bytes of the word in flight
    logic [1:0]              byte_cnt;
    logic [CW-1:0]           word_cnt;

    logic accept, last_byte, overflow, commit, halt_seen;
    logic [DATA_WIDTH-1:0]   word;

    assign word = {shift_q, i_rx_data};

    always_ff @(posedge i_clock) begin
        if (i_reset) state <= IDLE;
        else         state <= next_state;
    end

    always_comb begin
        next_state = state;
        accept     = (state == LOAD) && i_rx_done;
        last_byte  = accept && (byte_cnt == 2'd3);
        overflow   = last_byte && (word_cnt == MAX_WORDS);
        commit     = last_byte && !overflow;
        // HALT is detected on the registered word so o_loading covers the commit cycle
        halt_seen  = (state == LOAD) && o_wr_en &&
                     (o_instruccion[DATA_WIDTH-1 -: SIZEOP] == {SIZEOP{1'b1}});
        case (state)
            IDLE: if (i_start) next_state = LOAD;
            LOAD: begin
                if (overflow)       next_state = ERR;
                else if (halt_seen) next_state = DONE;
            end
            DONE: if (i_start) next_state = LOAD;
            ERR:  if (i_start) next_state = LOAD;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            shift_q       <= '0;
            byte_cnt      <= '0;
            word_cnt      <= '0;
            o_instruccion <= '0;
            o_address     <= '0;
            o_wr_en       <= 1'b0;
            o_loading     <= 1'b0;
            o_done        <= 1'b0;
            o_error       <= 1'b0;
        end else begin
            o_wr_en   <= commit;
            o_loading <= (next_state == LOAD);
            o_done    <= (next_state == DONE);
            o_error   <= (next_state == ERR);
            if (state != LOAD && i_start) begin
                byte_cnt <= '0;
                word_cnt <= '0;
            end else if (accept) begin
                shift_q  <= word[DATA_WIDTH-9:0];
                byte_cnt <= byte_cnt + 2'd1;
                if (commit) begin
                    o_instruccion <= word;
                    o_address     <= DATA_WIDTH'(word_cnt);
                    word_cnt      <= word_cnt + 1'b1;
                end
            end
        end
    end

    assign o_word_count = word_cnt;

endmodule

// File: tb/tb_instr_loader.sv
// Randomized self-checking bench for instr_loader; expected commits come from a
// word-level model of the byte stream.
module tb_instr_loader;

    localparam int DW = 32;
    localparam int MD = 32;
    localparam int CW = $clog2(MD) + 1;

    logic          clk = 1'b0;
    logic          rst;
    logic [7:0]    rx_data;
    logic          rx_done;
    logic          start;
    logic [DW-1:0] instr;
    logic [DW-1:0] addr;
    logic          loading;
    logic          wr_en;
    logic          done;
    logic          error;
    logic [CW-1:0] word_count;

    always #5 clk = ~clk;

    instr_loader #(.DATA_WIDTH(DW), .MEM_DEPTH(MD), .SIZEOP(6)) dut (
        .i_clock(clk), .i_reset(rst), .i_rx_data(rx_data), .i_rx_done(rx_done),
        .i_start(start), .o_instruccion(instr), .o_address(addr),
        .o_loading(loading), .o_wr_en(wr_en), .o_done(done), .o_error(error),
        .o_word_count(word_count)
    );

    typedef struct {
        logic [31:0] a;
        logic [31:0] w;
        int          c;
    } commit_t;

    commit_t     obs[$];
    logic [31:0] exp_q[$];
    bit          exp_done, exp_err;
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;

    always @(posedge clk) cyc++;
    always @(negedge clk) if (!rst && wr_en) obs.push_back('{addr, instr, cyc});

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
        obs.delete();
    endtask

    // Leaves the caller one cycle after the final byte strobe
    task automatic send_bytes(input logic [7:0] b[$], input int maxgap);
        for (int i = 0; i < b.size(); i++) begin
            rx_data = b[i];
            rx_done = 1'b1;
            tick();
            rx_done = 1'b0;
            if (maxgap > 0 && i != b.size() - 1) repeat ($urandom_range(maxgap, 0)) tick();
        end
    endtask

    function automatic logic [7:0] non_halt_byte();
        logic [7:0] b;
        b = 8'($urandom);
        if (b[7:2] == 6'h3f) b[2] = 1'b0;
        return b;
    endfunction

    // Word-level model: group bytes into big-endian words, stop at HALT or full memory
    task automatic model(input logic [7:0] b[$]);
        logic [31:0] w;
        exp_q.delete();
        exp_done = 0;
        exp_err  = 0;
        for (int i = 0; i + 3 < b.size() && !exp_done && !exp_err; i += 4) begin
            w = {b[i], b[i+1], b[i+2], b[i+3]};
            if (exp_q.size() == MD) exp_err = 1;
            else begin
                exp_q.push_back(w);
                if (w[31:26] == 6'h3f) exp_done = 1;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        checks++;
        if ({instr, addr, loading, wr_en, done, error, word_count} !== '0) begin
            errors++;
            $display("FAIL reset_outputs instr=%h addr=%h ld=%b we=%b dn=%b er=%b cnt=%0d want all 0",
                     instr, addr, loading, wr_en, done, error, word_count);
        end
        rst = 1'b0;
        tick();
        obs.delete();
    endtask

    task automatic test_single_word();
        logic [7:0] b[$];
        do_start();
        checks++;
        if (loading !== 1'b1) begin errors++; $display("FAIL start_loading got %b want 1", loading); end
        b = '{8'h20, 8'h01};
        send_bytes(b, 0);
        do_start();   // ignored while loading
        b = '{8'h00, 8'h05};
        send_bytes(b, 0);
        checks++;
        if (wr_en !== 1'b1 || instr !== 32'h20010005 || addr !== 32'd0 || word_count !== CW'(1)) begin
            errors++;
            $display("FAIL single_commit we=%b instr=%h addr=%h cnt=%0d want 1 20010005 0 1",
                     wr_en, instr, addr, word_count);
        end
        tick();
        checks++;
        if (wr_en !== 1'b0 || obs.size() != 1) begin
            errors++;
            $display("FAIL single_pulse we=%b pulses=%0d want 0 1", wr_en, obs.size());
        end
    endtask

    task automatic test_halt();
        logic [7:0] b[$];
        do_reset();
        for (int i = 0; i < 12; i++) b.push_back(i % 4 == 0 ? non_halt_byte() : 8'($urandom));
        b.push_back(8'hFC); b.push_back(8'h00); b.push_back(8'h00); b.push_back(8'h00);
        model(b);
        do_start();
        send_bytes(b, 2);
        checks++;
        if (wr_en !== 1'b1 || loading !== 1'b1 || done !== 1'b0 || instr !== 32'hFC000000) begin
            errors++;
            $display("FAIL halt_commit we=%b ld=%b dn=%b instr=%h want 1 1 0 fc000000", wr_en, loading, done, instr);
        end
        tick();
        checks++;
        if (done !== 1'b1 || loading !== 1'b0 || word_count !== CW'(4)) begin
            errors++;
            $display("FAIL halt_done dn=%b ld=%b cnt=%0d want 1 0 4", done, loading, word_count);
        end
        checks++;
        if (obs.size() != exp_q.size()) begin
            errors++;
            $display("FAIL halt_count got %0d want %0d", obs.size(), exp_q.size());
        end else
            for (int i = 0; i < obs.size(); i++)
                if (obs[i].a !== 32'(i) || obs[i].w !== exp_q[i]) begin
                    errors++;
                    $display("FAIL halt_word%0d got %h@%0d want %h@%0d", i, obs[i].w, obs[i].a, exp_q[i], i);
                end
    endtask

    task automatic test_idle_bytes();
        logic [7:0] b[$];
        do_reset();
        b = '{8'hAA, 8'hBB, 8'hCC};
        send_bytes(b, 1);
        tick();
        checks++;
        if (obs.size() != 0 || loading !== 1'b0 || word_count !== '0) begin
            errors++;
            $display("FAIL idle_ignored pulses=%0d ld=%b cnt=%0d want 0 0 0", obs.size(), loading, word_count);
        end
        b = '{non_halt_byte(), 8'($urandom), 8'($urandom), 8'($urandom)};
        do_start();
        send_bytes(b, 1);
        tick();
        checks++;
        if (obs.size() != 1 || obs[0].w !== {b[0], b[1], b[2], b[3]} || obs[0].a !== 32'd0) begin
            errors++;
            $display("FAIL idle_then_load pulses=%0d word=%h want 1 %h", obs.size(),
                     obs.size() > 0 ? obs[0].w : 32'h0, {b[0], b[1], b[2], b[3]});
        end
    endtask

    task automatic test_overflow();
        logic [7:0] b[$];
        do_reset();
        for (int i = 0; i < (MD + 1) * 4; i++) b.push_back(i % 4 == 0 ? non_halt_byte() : 8'($urandom));
        model(b);
        do_start();
        send_bytes(b, 0);
        checks++;
        if (error !== 1'b1 || loading !== 1'b0 || wr_en !== 1'b0 || error !== exp_err) begin
            errors++;
            $display("FAIL overflow_err er=%b ld=%b we=%b want 1 0 0", error, loading, wr_en);
        end
        tick();
        checks++;
        if (obs.size() != exp_q.size() || word_count !== CW'(MD)) begin
            errors++;
            $display("FAIL overflow_count pulses=%0d cnt=%0d want %0d %0d", obs.size(), word_count, exp_q.size(), MD);
        end else
            for (int i = 0; i < obs.size(); i++)
                if (obs[i].a !== 32'(i) || obs[i].w !== exp_q[i]) begin
                    errors++;
                    $display("FAIL overflow_word%0d got %h@%0d want %h@%0d", i, obs[i].w, obs[i].a, exp_q[i], i);
                end
    endtask

    task automatic test_reset_mid_word();
        logic [7:0] b[$];
        do_reset();
        do_start();
        b = '{8'hDE, 8'hAD};
        send_bytes(b, 0);
        rst = 1'b1;
        start = 1'b1;
        rx_done = 1'b1;
        tick();
        checks++;
        if ({instr, addr, loading, wr_en, done, error, word_count} !== '0) begin
            errors++;
            $display("FAIL midreset_outputs instr=%h addr=%h ld=%b we=%b cnt=%0d want all 0",
                     instr, addr, loading, wr_en, word_count);
        end
        rst = 1'b0;
        start = 1'b0;
        rx_done = 1'b0;
        tick();
        obs.delete();
        do_start();
        b = '{8'h11, 8'h22, 8'h33, 8'h44};
        send_bytes(b, 0);
        checks++;
        if (wr_en !== 1'b1 || instr !== 32'h11223344 || addr !== 32'd0) begin
            errors++;
            $display("FAIL midreset_commit we=%b instr=%h addr=%h want 1 11223344 0", wr_en, instr, addr);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] b[$];
        do_reset();
        for (int i = 0; i < 8; i++) b.push_back(i % 4 == 0 ? non_halt_byte() : 8'($urandom));
        b.push_back(8'hFF); b.push_back(8'($urandom)); b.push_back(8'($urandom)); b.push_back(8'($urandom));
        model(b);
        do_start();
        send_bytes(b, 0);
        tick();
        checks++;
        if (obs.size() != 3) begin
            errors++;
            $display("FAIL b2b_pulses got %0d want 3", obs.size());
        end else
            for (int i = 0; i < 3; i++)
                if (obs[i].a !== 32'(i) || obs[i].w !== exp_q[i] || (i > 0 && obs[i].c - obs[i-1].c != 4)) begin
                    errors++;
                    $display("FAIL b2b_word%0d got %h@%0d cyc=%0d want %h@%0d spacing 4",
                             i, obs[i].w, obs[i].a, obs[i].c, exp_q[i], i);
                end
        checks++;
        if (done !== exp_done || loading !== 1'b0) begin
            errors++;
            $display("FAIL b2b_done dn=%b ld=%b want 1 0", done, loading);
        end
        do_start();
        checks++;
        if (loading !== 1'b1 || done !== 1'b0 || word_count !== '0 || instr !== exp_q[2]) begin
            errors++;
            $display("FAIL b2b_restart ld=%b dn=%b cnt=%0d instr=%h want 1 0 0 %h",
                     loading, done, word_count, instr, exp_q[2]);
        end
    endtask

    task automatic test_random();
        logic [7:0] b[$];
        int nw;
        for (int s = 0; s < 8; s++) begin
            b.delete();
            nw = $urandom_range(10, 1);
            for (int i = 0; i < nw * 4 + $urandom_range(3, 0); i++)
                b.push_back(i % 4 == 0 && $urandom_range(3, 0) == 0 ? 8'hFC | 8'($urandom_range(3, 0))
                                                                    : 8'($urandom));
            model(b);
            do_reset();
            do_start();
            send_bytes(b, 2);
            tick();
            tick();
            checks++;
            if (done !== exp_done || error !== exp_err || word_count !== CW'(exp_q.size())) begin
                errors++;
                $display("FAIL rand%0d_status dn=%b er=%b cnt=%0d want %b %b %0d",
                         s, done, error, word_count, exp_done, exp_err, exp_q.size());
            end
            checks++;
            if (obs.size() != exp_q.size()) begin
                errors++;
                $display("FAIL rand%0d_count got %0d want %0d", s, obs.size(), exp_q.size());
            end else
                for (int i = 0; i < obs.size(); i++)
                    if (obs[i].a !== 32'(i) || obs[i].w !== exp_q[i]) begin
                        errors++;
                        $display("FAIL rand%0d_word%0d got %h@%0d want %h@%0d", s, i, obs[i].w, obs[i].a, exp_q[i], i);
                    end
        end
    endtask

    initial begin
        rst     = 1'b1;
        rx_data = 8'h00;
        rx_done = 1'b0;
        start   = 1'b0;
        tick();
        test_reset();
        test_single_word();
        test_halt();
        test_idle_bytes();
        test_overflow();
        test_reset_mid_word();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/instr_loader.md
# instr_loader

Byte-to-word loader that fills the instruction memory before execution. It sits directly upstream of the instruction memory. It takes the 8-bit byte stream from the UART receiver, assembles big-endian 32-bit instructions and drives the memory's load port (instruction, address, loading). It stops when it has committed a HALT instruction (opcode 6'b111111) or when the memory is full.

## Interface
Parameters:
- DATA_WIDTH, 32, instruction and address width.
- MEM_DEPTH, 32, number of instruction-memory words.
- SIZEOP, 6, opcode field width.

Ports:
- i_clock  in  1  system clock; all logic on posedge.
- i_reset  in  1  reset; synchronous, active-high.
- i_rx_data  in  8  received byte.
- i_rx_done  in  1  one-cycle strobe: i_rx_data valid this cycle.
- i_start  in  1  begin a load session (level or pulse, sampled per cycle).
- o_instruccion  out  DATA_WIDTH  last assembled word; feeds memory i_instruccion.
- o_address  out  DATA_WIDTH  word index of o_instruccion; feeds memory i_address.
- o_loading  out  1  high while in LOAD; feeds memory i_loading.
- o_wr_en  out  1  one-cycle pulse when a new word/address pair is presented.
- o_done  out  1  load finished with HALT committed.
- o_error  out  1  memory overflow (MEM_DEPTH words without HALT).
- o_word_count  out  $clog2(MEM_DEPTH)+1  words committed this session.

## Operation
- States: IDLE, LOAD, DONE, ERR. Reset state is IDLE.
- IDLE: bytes are ignored. On i_start, go to LOAD next cycle with byte counter and word counter cleared.
- LOAD: each i_rx_done shifts i_rx_data into a 32-bit shift register. The first byte lands in bits 31:24 and the fourth in bits 7:0. A 2-bit byte counter wraps 3→0.
- Commit on the 4th byte:
  - o_instruccion ← the assembled word.
  - o_address ← the word counter (zero-extended).
  - o_wr_en = 1 for one cycle.
  - The word counter increments.
  - o_instruccion and o_address update only on commit, together, and hold between commits.
- HALT: if the committed word has bits[31:26] == 6'b111111, the block enters DONE the cycle after the commit cycle. o_loading stays high through the commit cycle, so the memory receives HALT.
- Overflow: if a 4th byte completes while word count == MEM_DEPTH, no commit occurs and the block goes to ERR.
- DONE: o_done = 1, o_loading = 0, bytes ignored.
- ERR: o_error = 1, o_loading = 0, bytes ignored.
- i_start in DONE or ERR restarts. The next cycle is LOAD, with counters, o_done and o_error cleared. o_instruccion and o_address keep their values until the next commit.
- i_start in LOAD is ignored.
- A byte arriving in the same cycle as a commit is accepted normally as byte 0 of the next word.
- i_reset at any time (including mid-word):
  - State returns to IDLE and the partial word is discarded.
  - All outputs reset: o_instruccion = 0, o_address = 0, o_loading = 0, o_wr_en = 0, o_done = 0, o_error = 0, o_word_count = 0.
  - Reset has priority over i_start and i_rx_done.

## Timing
- The 4th byte strobe in cycle t produces, in cycle t+1: o_instruccion and o_address valid, o_wr_en = 1, o_word_count incremented.
- On a HALT commit, o_loading falls and o_done rises in cycle t+2.
- On overflow, o_loading falls and o_error rises in cycle t+1.
- i_start in cycle t puts o_loading high from t+1.
- o_loading is a registered level. The instruction memory samples it on the negedge within the commit cycle, which gives half a cycle of setup.
- Maximum throughput: one byte per cycle, hence one commit every 4 cycles.

## Test plan
- Reset, start, then bytes 0x20,0x01,0x00,0x05 -> one o_wr_en pulse with o_instruccion = 0x20010005 and o_address = 0; o_word_count = 1.
- Three ordinary words, then 0xFC,0x00,0x00,0x00 -> commits at addresses 0..3 with the last word 0xFC000000; o_done = 1 and o_loading = 0 two cycles after the last byte; o_word_count = 4.
- Bytes sent in IDLE, then start, then 4 bytes -> first commit at address 0 containing only the post-start bytes.
- 32 non-HALT words, then 4 more bytes -> 32 o_wr_en pulses (addresses 0..31); no 33rd pulse; o_error = 1 one cycle after the 4th extra byte.
- Start, 2 bytes, i_reset, start, bytes 0x11,0x22,0x33,0x44 -> commit 0x11223344 at address 0; all outputs 0 during reset.
- i_rx_done high every cycle for 12 bytes -> o_wr_en pulses exactly 4 cycles apart at addresses 0, 1, 2; DONE, then i_start -> LOAD with o_word_count = 0 and o_done = 0.
